uart_tx_hs: RTL

//  Serial-line transmitter downstream of the keyboard-to-serial control FSM.

---
 rtl/uart_tx_hs.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_hs.sv
// Byte-per-handshake UART transmitter: 8N1, or 8E1 when UART_PARITY_EN is defined.
// s_req/s_ack four-phase handshake; tx, s_ack and busy are all registered.
module uart_tx_hs #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       s_req,
   input  logic [7:0] s_data,
   output logic       s_ack,
   output logic       tx,
   output logic       busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, ACK_HI} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, ACK_HI} state_t;
`endif

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      data_q, data_d;
   logic            tx_q, tx_d;
   logic            ack_q, ack_d;
   logic            busy_q, busy_d;
   logic            bit_end;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         tx_q    <= 1'b1;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         tx_q    <= tx_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      data_d  = data_q;
      tx_d    = tx_q;
      ack_d   = ack_q;
      busy_d  = busy_q;
      bit_end = (cnt_q == CNT_LAST);

      case (state_q)
         IDLE: begin
            tx_d  = 1'b1;
            ack_d = 1'b0;
            if (s_req) begin
               data_d  = s_data;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               tx_d    = data_q[0];
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               idx_d = idx_q + 3'd1;
               // index wraps 7 -> 0 as the last data bit finishes
               if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  tx_d    = ^data_q;
                  state_d = PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  tx_d = data_q[idx_d];
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`ifdef UART_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               tx_d    = 1'b1;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               cnt_d   = '0;
               ack_d   = 1'b1;
               state_d = ACK_HI;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ACK_HI: begin
            tx_d = 1'b1;
            if (!s_req) begin
               ack_d   = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            tx_d    = 1'b1;
            ack_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign tx    = tx_q;
   assign s_ack = ack_q;
   assign busy  = busy_q;

endmodule
